// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited imem requests, and an
// in-order instruction buffer toward decode. Optional perf counters: FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = 32'h0000_0000,
    parameter int               BUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pc_en,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  br_target,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [XLEN-1:0]  imem_rsp_data,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [XLEN-1:0]  id_inst,
    output logic [XLEN-1:0]  id_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_flushed
`endif
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;

    state_t          state_reg;
    logic [XLEN-1:0] pc_reg;
    logic [CW-1:0]   outstanding_reg;
    logic [CW-1:0]   drop_reg;
    logic [CW-1:0]   count_reg;
    logic [AW-1:0]   rd_ptr_reg, wr_ptr_reg;
    logic [AW-1:0]   fq_rd_reg, fq_wr_reg;
    logic            req_hold_reg;

    logic [XLEN-1:0] inst_mem [BUF_DEPTH];
    logic [XLEN-1:0] pcb_mem  [BUF_DEPTH];
    logic [XLEN-1:0] fq_mem   [BUF_DEPTH];

    logic            pop, push, rsp_fire, req_fire, credit, drop_now;
    logic [CW-1:0]   occ_after;
    logic [CW:0]     credit_sum;

    assign id_valid   = (count_reg != '0);
    assign pop        = id_valid && id_ready;
    assign rsp_fire   = imem_rsp_valid && (outstanding_reg != '0);
    assign drop_now   = (drop_reg != '0);
    assign push       = rsp_fire && !drop_now && !br_taken;
    // A slot freed by this cycle's pop can be re-credited: its response lands next cycle at the earliest.
    assign occ_after  = count_reg - CW'(pop);
    assign credit_sum = {1'b0, outstanding_reg} + {1'b0, occ_after};
    assign credit     = credit_sum < (CW+1)'(BUF_DEPTH);

    // An un-accepted request keeps its credit so valid/addr stay stable until taken.
    assign imem_req_valid = !br_taken && !drop_now &&
                            (req_hold_reg || (state_reg == RUN && credit));
    assign imem_req_addr  = pc_reg;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign id_inst = id_valid ? inst_mem[rd_ptr_reg] : '0;
    assign id_pc   = id_valid ? pcb_mem[rd_ptr_reg]  : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= BOOT;
        end else begin
            case (state_reg)
                BOOT:    state_reg <= RUN;
                RUN:     if (!pc_en) state_reg <= HOLD;
                HOLD:    if (pc_en)  state_reg <= RUN;
                default: state_reg <= BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg          <= RESET_PC;
            outstanding_reg <= '0;
            drop_reg        <= '0;
            count_reg       <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            fq_rd_reg       <= '0;
            fq_wr_reg       <= '0;
            req_hold_reg    <= 1'b0;
        end else if (br_taken) begin
            // Every in-flight response is now stale, including one arriving this cycle.
            pc_reg          <= {br_target[XLEN-1:2], 2'b00};
            outstanding_reg <= outstanding_reg - CW'(rsp_fire);
            drop_reg        <= outstanding_reg - CW'(rsp_fire);
            count_reg       <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            fq_rd_reg       <= '0;
            fq_wr_reg       <= '0;
            req_hold_reg    <= 1'b0;
        end else begin
            if (req_fire) begin
                pc_reg    <= pc_reg + XLEN'(4);
                fq_wr_reg <= fq_wr_reg + AW'(1);
            end
            outstanding_reg <= outstanding_reg + CW'(req_fire) - CW'(rsp_fire);
            if (rsp_fire && drop_now) drop_reg <= drop_reg - CW'(1);
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
                fq_rd_reg  <= fq_rd_reg + AW'(1);
            end
            if (pop) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg    <= count_reg + CW'(push) - CW'(pop);
            req_hold_reg <= imem_req_valid && !imem_req_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) fq_mem[fq_wr_reg] <= pc_reg;
        if (push) begin
            inst_mem[wr_ptr_reg] <= imem_rsp_data;
            pcb_mem[wr_ptr_reg]  <= fq_mem[fq_rd_reg];
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [CW:0] flush_cnt;
    always_comb begin
        flush_cnt = '0;
        if (br_taken)
            flush_cnt = {1'b0, occ_after} + (CW+1)'(rsp_fire);
        else if (rsp_fire && drop_now)
            flush_cnt = (CW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= perf_fetched + 32'(pop);
            perf_flushed <= perf_flushed + 32'(flush_cnt);
        end
    end
`endif

    a_rsp_needs_outstanding: assert property (
        @(posedge clk) disable iff (!rst_n) imem_rsp_valid |-> (outstanding_reg != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: imem model plus an instruction-stream reference model,
// directed redirect table, hand-written corner sequences, then random traffic.
module tb_fetch_unit;
    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          BUF_DEPTH = 2;

    logic        clk, rst_n, pc_en, br_taken, id_ready;
    logic [31:0] br_target;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data;
    logic        id_valid;
    logic [31:0] id_inst, id_pc;

    fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .pc_en(pc_en), .br_taken(br_taken), .br_target(br_target),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .id_valid(id_valid), .id_ready(id_ready),
        .id_inst(id_inst), .id_pc(id_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int hs_count = 0;
    logic [31:0] pending[$];
    logic [31:0] hs_q[$];
    logic [31:0] exp_pc;
    logic        br_seen_prev;
    logic        fast, rsp_hold;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input int n, input string name);
        int start = hs_count;
        int c = 0;
        while (hs_count < start + n && c < 200) begin
            step();
            c++;
        end
        chk({name, "_timeout"}, 32'(hs_count >= start + n), 32'd1);
    endtask

    // imem: in-order responses from the accepted-address queue, >=1 cycle later.
    always @(posedge clk) begin
        #1;
        imem_req_ready = fast ? 1'b1 : ($urandom % 4 != 0);
        if (pending.size() > 0 && !rsp_hold && (fast || $urandom % 3 != 0)) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pending[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    end

    // Reference model: decode sees PCs advancing by 4, restarting at each redirect target.
    always @(negedge clk) begin
        if (imem_rsp_valid && pending.size() > 0) void'(pending.pop_front());
        if (rst_n) begin
            if (br_seen_prev) chk("id_valid_after_redirect", 32'(id_valid), 32'd0);
            if (imem_req_valid && imem_req_ready) pending.push_back(imem_req_addr);
            chk("outstanding_bound", 32'(pending.size() <= BUF_DEPTH), 32'd1);
            if (id_valid && id_ready) begin
                chk("id_pc", id_pc, exp_pc);
                chk("id_inst", id_inst, mem_word(exp_pc));
                hs_q.push_back(id_pc);
                hs_count++;
                exp_pc = exp_pc + 32'd4;
            end
            br_seen_prev = br_taken;
            if (br_taken) exp_pc = br_target & ~32'd3;
        end
    end

    typedef struct {
        logic [31:0] tgt;
        logic        b2b;
        logic [31:0] tgt2;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{32'h0000_0103, 1'b0, 32'h0, 32'h0000_0100, 32'h0000_0104};
        tbl[1] = '{32'hFFFF_FFFE, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'h0000_0000};
        tbl[2] = '{32'h0000_2001, 1'b0, 32'h0, 32'h0000_2000, 32'h0000_2004};
        tbl[3] = '{32'h0000_0004, 1'b0, 32'h0, 32'h0000_0004, 32'h0000_0008};
        tbl[4] = '{32'h0000_0500, 1'b1, 32'h0000_0603, 32'h0000_0600, 32'h0000_0604};
        tbl[5] = '{32'h8000_0FFA, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};

        rst_n = 1'b0; pc_en = 1'b0; br_taken = 1'b0; br_target = 32'h0; id_ready = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        fast = 1'b1; rsp_hold = 1'b0; exp_pc = RESET_PC; br_seen_prev = 1'b0;
        #3;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_id_inst", id_inst, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        step(); step();
        rst_n = 1'b1; pc_en = 1'b1; id_ready = 1'b1;

        // Sequential fetch from reset and steady-state throughput.
        wait_hs(3, "boot");
        chk("boot_pc0", hs_q[0], 32'h0);
        chk("boot_pc1", hs_q[1], 32'h4);
        chk("boot_pc2", hs_q[2], 32'h8);
        repeat (5) step();
        begin
            int start = hs_count;
            repeat (20) step();
            chk("throughput_ge19", 32'((hs_count - start) >= 19), 32'd1);
        end

        // Decode stall: credit exhausts, then the stream resumes losslessly.
        id_ready = 1'b0;
        repeat (10) step();
        @(negedge clk);
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_id_valid", 32'(id_valid), 32'd1);
        step();
        id_ready = 1'b1;
        wait_hs(4, "stall_release");

        // Fetch hold: nothing new requested, resumes sequentially.
        pc_en = 1'b0;
        repeat (3) step();
        begin
            int reqs = 0;
            repeat (5) begin
                @(negedge clk);
                if (imem_req_valid) reqs++;
            end
            chk("hold_no_requests", 32'(reqs), 32'd0);
        end
        step();
        pc_en = 1'b1;
        wait_hs(4, "hold_resume");

        // Redirect with two responses outstanding: both must be dropped.
        rsp_hold = 1'b1;
        repeat (4) step();
        chk("two_outstanding", 32'(pending.size()), 32'd2);
        br_taken = 1'b1; br_target = 32'h0000_0103;
        step();
        br_taken = 1'b0; rsp_hold = 1'b0;
        hs_q.delete();
        wait_hs(1, "drop2");
        chk("drop2_first_pc", hs_q[0], 32'h0000_0100);

        // Redirect table, including wrap and back-to-back redirects.
        for (int i = 0; i < 6; i++) begin
            step();
            br_taken = 1'b1; br_target = tbl[i].tgt;
            if (tbl[i].b2b) begin
                step();
                br_target = tbl[i].tgt2;
            end
            step();
            br_taken = 1'b0;
            hs_q.delete();
            wait_hs(2, "table");
            if (hs_q.size() >= 2) begin
                chk($sformatf("table%0d_pc0", i), hs_q[0], tbl[i].exp0);
                chk($sformatf("table%0d_pc1", i), hs_q[1], tbl[i].exp1);
            end
            repeat (3) step();
        end

        // Random traffic against the reference model.
        fast = 1'b0;
        for (int c = 0; c < 2500; c++) begin
            step();
            id_ready  = ($urandom % 4 != 0);
            pc_en     = ($urandom % 8 != 0);
            br_taken  = ($urandom % 32 == 0);
            br_target = $urandom;
        end
        step();
        br_taken = 1'b0; pc_en = 1'b1; id_ready = 1'b1; fast = 1'b1;
        wait_hs(4, "random_tail");

        // Reset mid-stream with responses in flight.
        rsp_hold = 1'b1; id_ready = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("midrst_req_addr", imem_req_addr, RESET_PC);
        chk("midrst_id_valid", 32'(id_valid), 32'd0);
        chk("midrst_id_pc", id_pc, 32'h0);
        rsp_hold = 1'b0;
        exp_pc = RESET_PC; br_seen_prev = 1'b0;
        repeat (4) step();
        @(negedge clk);
        pending.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1; id_ready = 1'b1;
        hs_q.delete();
        wait_hs(3, "restart");
        if (hs_q.size() >= 2) begin
            chk("restart_pc0", hs_q[0], RESET_PC);
            chk("restart_pc1", hs_q[1], RESET_PC + 32'd4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
